// File: rtl/quiz_pkg.sv
// Shared types and defaults for the Braille trainer quiz round controller.
package quiz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        CHECK,
        PRESENT,
        RESULT,
        DONE
    } state_t;

    typedef logic [3:0] symbol_t;

    localparam int DEF_NUM_ROUNDS     = 10;
    localparam int DEF_MAX_SYMBOL     = 9;
    localparam int DEF_MAX_REDRAW     = 3;
    localparam int DEF_TIMEOUT_CYCLES = 50_000_000;
    localparam int DEF_RESULT_CYCLES  = 25_000_000;
    localparam int TIMER_W            = 32;

    // Maps an out-of-range draw back into 0..max_symbol.
    function automatic symbol_t fold_symbol(input symbol_t v, input int max_symbol);
        logic [4:0] wide;
        wide = {1'b0, v} - 5'(max_symbol + 1);
        return wide[3:0];
    endfunction

    function automatic symbol_t next_symbol(input symbol_t v, input int max_symbol);
        return (int'(v) >= max_symbol) ? '0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/quiz_timer.sv
// Loadable down-counter; tc is high while enabled and the count has reached zero.
module quiz_timer
    import quiz_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = en && (count_q == '0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Session sequencer for the Braille trainer: draw, validate, present, score, repeat.
// Optional macro QUIZ_NO_REPEAT_EN rejects a draw equal to the previous round's target.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_ROUNDS     = DEF_NUM_ROUNDS,
    parameter int MAX_SYMBOL     = DEF_MAX_SYMBOL,
    parameter int MAX_REDRAW     = DEF_MAX_REDRAW,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RESULT_CYCLES  = DEF_RESULT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [3:0] answer,
    input  logic [3:0] rng_in,
    output logic       rng_update,
    output logic [3:0] target,
    output logic       target_valid,
    output logic       result_correct,
    output logic       result_wrong,
    output logic       timed_out,
    output logic [7:0] score,
    output logic [7:0] round_idx,
    output logic       busy,
    output logic       done
);

    localparam symbol_t    MAX_SYM    = symbol_t'(MAX_SYMBOL);
    localparam logic [7:0] REDRAW_LIM = 8'(MAX_REDRAW);
    localparam logic [7:0] ROUNDS_LIM = 8'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [7:0] redraw_q, redraw_d;
    logic [7:0] score_q, score_d;
    logic [7:0] round_q, round_d;
    symbol_t    target_q, target_d;
    logic       rng_update_q, rng_update_d;
    logic       target_valid_q, target_valid_d;
    logic       correct_q, correct_d;
    logic       wrong_q, wrong_d;
    logic       timed_out_q, timed_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic    tmo_load, tmo_tc, res_load, res_tc;
    logic    draw_ok;
    symbol_t fallback;

`ifdef QUIZ_NO_REPEAT_EN
    symbol_t prev_q, prev_d;
    logic    has_prev_q, has_prev_d;

    always_comb begin
        draw_ok  = (rng_in <= MAX_SYM) && !(has_prev_q && (rng_in == prev_q));
        fallback = (rng_in > MAX_SYM) ? fold_symbol(rng_in, MAX_SYMBOL) : rng_in;
        if (has_prev_q && (fallback == prev_q)) begin
            fallback = next_symbol(fallback, MAX_SYMBOL);
        end
    end
`else
    assign draw_ok  = (rng_in <= MAX_SYM);
    assign fallback = fold_symbol(rng_in, MAX_SYMBOL);
`endif

    quiz_timer #(.W(TIMER_W)) u_answer_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (TIMER_W'(TIMEOUT_CYCLES - 1)),
        .en       (state_q == PRESENT),
        .tc       (tmo_tc)
    );

    quiz_timer #(.W(TIMER_W)) u_result_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (res_load),
        .load_val (TIMER_W'(RESULT_CYCLES - 1)),
        .en       (state_q == RESULT),
        .tc       (res_tc)
    );

    always_comb begin
        state_d     = state_q;
        redraw_d    = redraw_q;
        score_d     = score_q;
        round_d     = round_q;
        target_d    = target_q;
        correct_d   = 1'b0;
        wrong_d     = 1'b0;
        timed_out_d = 1'b0;
        tmo_load    = 1'b0;
        res_load    = 1'b0;
`ifdef QUIZ_NO_REPEAT_EN
        prev_d      = prev_q;
        has_prev_d  = has_prev_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    score_d  = '0;
                    round_d  = '0;
                    redraw_d = '0;
                    state_d  = DRAW;
`ifdef QUIZ_NO_REPEAT_EN
                    has_prev_d = 1'b0;
`endif
                end
            end
            DRAW: state_d = CHECK;
            CHECK: begin
                if (draw_ok) begin
                    target_d = rng_in;
                    state_d  = PRESENT;
                end else if (redraw_q < REDRAW_LIM) begin
                    redraw_d = redraw_q + 8'd1;
                    state_d  = DRAW;
                end else begin
                    target_d = fallback;
                    state_d  = PRESENT;
                end
                if (state_d == PRESENT) begin
                    redraw_d = '0;
                    tmo_load = 1'b1;
`ifdef QUIZ_NO_REPEAT_EN
                    prev_d     = target_d;
                    has_prev_d = 1'b1;
`endif
                end
            end
            PRESENT: begin
                // A submit in the final timeout cycle still counts as an answer.
                if (submit) begin
                    correct_d = (answer == target_q);
                    wrong_d   = (answer != target_q);
                    state_d   = RESULT;
                end else if (tmo_tc) begin
                    wrong_d     = 1'b1;
                    timed_out_d = 1'b1;
                    state_d     = RESULT;
                end
                if (state_d == RESULT) begin
                    res_load = 1'b1;
                    round_d  = round_q + 8'd1;
                    if (correct_d && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                    end
                end
            end
            RESULT: begin
                if (res_tc) begin
                    state_d = (round_q == ROUNDS_LIM) ? DONE : DRAW;
                end else begin
                    correct_d   = correct_q;
                    wrong_d     = wrong_q;
                    timed_out_d = timed_out_q;
                end
            end
            default: state_d = IDLE;
        endcase

        rng_update_d   = (state_d == DRAW);
        target_valid_d = (state_d == PRESENT);
        busy_d         = (state_d != IDLE) && (state_d != DONE);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            redraw_q       <= '0;
            score_q        <= '0;
            round_q        <= '0;
            target_q       <= '0;
            rng_update_q   <= 1'b0;
            target_valid_q <= 1'b0;
            correct_q      <= 1'b0;
            wrong_q        <= 1'b0;
            timed_out_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef QUIZ_NO_REPEAT_EN
            prev_q         <= '0;
            has_prev_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            redraw_q       <= redraw_d;
            score_q        <= score_d;
            round_q        <= round_d;
            target_q       <= target_d;
            rng_update_q   <= rng_update_d;
            target_valid_q <= target_valid_d;
            correct_q      <= correct_d;
            wrong_q        <= wrong_d;
            timed_out_q    <= timed_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef QUIZ_NO_REPEAT_EN
            prev_q         <= prev_d;
            has_prev_q     <= has_prev_d;
`endif
        end
    end

    assign rng_update     = rng_update_q;
    assign target         = target_q;
    assign target_valid   = target_valid_q;
    assign result_correct = correct_q;
    assign result_wrong   = wrong_q;
    assign timed_out      = timed_out_q;
    assign score          = score_q;
    assign round_idx      = round_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
